ustate_sequencer: RTL and testbench

USTATE_SEQUENCER -- requirements
Module: ustate_sequencer

---
 rtl/ustate_sequencer.sv | 75 +++++++
 tb/tb_ustate_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ustate_sequencer.sv
// ustate_sequencer: microprogrammed sequencer with writable control store, memory wait and halt
module ustate_sequencer #(
    parameter int CS_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  nextst,
    output logic [1:0]  nssel,
    output logic [4:0]  dbin,
    output logic [6:0]  ctrl,
    output logic [4:0]  state,
    output logic        mem_req,
    input  logic        mem_rdy,
    output logic        halted,
    input  logic        run,
    input  logic        cs_we,
    input  logic [4:0]  cs_waddr,
    input  logic [15:0] cs_wdata
);
    typedef enum logic [1:0] {RUN, WAIT, HALT} fsm_t;
    fsm_t        fsm;
    logic [15:0] cs [CS_DEPTH];
    logic [15:0] uir;
    logic [15:0] fetch;
    logic        advance;
    assign nssel = uir[15:14];
    assign dbin  = uir[13:9];
    assign ctrl  = uir[6:0];
    // a write landing on the word being fetched is forwarded into uir
    assign fetch = (cs_we && cs_waddr == nextst) ? cs_wdata : cs[nextst];
    assign advance = (fsm == RUN  && !uir[8] && !uir[7]) ||
                     (fsm == WAIT && mem_rdy && !uir[7]) ||
                     (fsm == HALT && run);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            for (int i = 0; i < CS_DEPTH; i++) cs[i] <= '0;
        else if (cs_we)
            cs[cs_waddr] <= cs_wdata;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= '0;
            uir   <= '0;
        end else if (advance) begin
            state <= nextst;
            uir   <= fetch;
        end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            fsm     <= RUN;
            mem_req <= 1'b0;
            halted  <= 1'b0;
        end else begin
            case (fsm)
                RUN: begin
                    fsm     <= uir[8] ? WAIT : uir[7] ? HALT : RUN;
                    mem_req <= uir[8];
                    halted  <= !uir[8] && uir[7];
                end
                WAIT: if (mem_rdy) begin
                    fsm     <= uir[7] ? HALT : RUN;
                    mem_req <= 1'b0;
                    halted  <= uir[7];
                end
                HALT: if (run) begin
                    fsm    <= RUN;
                    halted <= 1'b0;
                end
                default: begin
                    fsm     <= RUN;
                    mem_req <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_ustate_sequencer.sv
// tb_ustate_sequencer: directed and randomized checks of ustate_sequencer against a behavioural model
module tb_ustate_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  nextst = '0;
    logic        mem_rdy = 1'b0;
    logic        run = 1'b0;
    logic        cs_we = 1'b0;
    logic [4:0]  cs_waddr = '0;
    logic [15:0] cs_wdata = '0;
    logic [1:0]  nssel;
    logic [4:0]  dbin;
    logic [4:0]  state;
    logic [6:0]  ctrl;
    logic        mem_req;
    logic        halted;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_cs [32];
    logic [15:0] m_word;
    logic [4:0]  m_state;
    logic        m_waiting;
    logic        m_halted;

    always #5 clk = ~clk;

    ustate_sequencer dut (
        .clk(clk), .reset_n(reset_n), .nextst(nextst), .nssel(nssel), .dbin(dbin),
        .ctrl(ctrl), .state(state), .mem_req(mem_req), .mem_rdy(mem_rdy),
        .halted(halted), .run(run), .cs_we(cs_we), .cs_waddr(cs_waddr), .cs_wdata(cs_wdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cs[i] = '0;
        m_word = '0;
        m_state = '0;
        m_waiting = 1'b0;
        m_halted = 1'b0;
    endtask

    // one clock of the sequencer described by its rules: wait, halt, or fetch the next word
    task automatic model_step(input logic [4:0] ns, input logic rdy, input logic rn,
                              input logic we, input logic [4:0] wa, input logic [15:0] wd);
        logic go;
        go = 1'b0;
        if (m_waiting) begin
            if (rdy) begin
                m_waiting = 1'b0;
                if (m_word[7]) m_halted = 1'b1;
                else go = 1'b1;
            end
        end else if (m_halted) begin
            if (rn) begin
                m_halted = 1'b0;
                go = 1'b1;
            end
        end else if (m_word[8]) m_waiting = 1'b1;
        else if (m_word[7]) m_halted = 1'b1;
        else go = 1'b1;
        if (go) begin
            m_state = ns;
            m_word = (we && wa == ns) ? wd : m_cs[ns];
        end
        if (we) m_cs[wa] = wd;
    endtask

    task automatic compare_all();
        check("state", 32'(state), 32'(m_state));
        check("nssel", 32'(nssel), 32'(m_word[15:14]));
        check("dbin", 32'(dbin), 32'(m_word[13:9]));
        check("ctrl", 32'(ctrl), 32'(m_word[6:0]));
        check("mem_req", 32'(mem_req), 32'(m_waiting));
        check("halted", 32'(halted), 32'(m_halted));
    endtask

    task automatic check_zero(input string tag);
        check(tag, {16'h0, 11'(nssel), dbin, ctrl}, 32'h0);
        check(tag, {16'h0, 11'(state), 3'b0, mem_req, halted}, 32'h0);
    endtask

    // called at a falling edge: drive inputs, take one rising edge, compare at the next falling edge
    task automatic cycle(input logic [4:0] ns, input logic rdy = 1'b0, input logic rn = 1'b0,
                         input logic we = 1'b0, input logic [4:0] wa = 5'd0, input logic [15:0] wd = 16'h0);
        nextst = ns; mem_rdy = rdy; run = rn; cs_we = we; cs_waddr = wa; cs_wdata = wd;
        @(posedge clk);
        model_step(ns, rdy, rn, we, wa, wd);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        nextst = '0; mem_rdy = 1'b0; run = 1'b0; cs_we = 1'b0; cs_waddr = '0; cs_wdata = '0;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_zero("reset_async");
        @(negedge clk);
        @(negedge clk);
        check_zero("reset_held");
        reset_n = 1'b1;
    endtask

    initial begin
        int req_cnt;
        logic [4:0] ns, wa;
        logic [15:0] wd;
        do_reset();
        // first edge after release advances normally, loading cs[3] via a prior write
        cycle(5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 16'h4A05);
        cycle(5'd3);
        check("load_state", 32'(state), 32'd3);
        check("load_fields", {16'h0, 11'(nssel), dbin, ctrl}, {16'h0, 11'd1, 5'd5, 7'h05});
        check("load_memreq", 32'(mem_req), 32'd0);
        // memory wait
        cycle(5'd3, 1'b0, 1'b0, 1'b1, 5'd4, 16'h0100);
        cycle(5'd4);
        req_cnt = 0;
        cycle(5'd7, 1'b0);
        if (mem_req) req_cnt++;
        for (int i = 0; i < 3; i++) begin
            cycle(5'd7, 1'b0, 1'b1);
            if (mem_req) req_cnt++;
            check("wait_hold_state", 32'(state), 32'd4);
        end
        cycle(5'd7, 1'b1);
        if (mem_req) req_cnt++;
        check("wait_req_cycles", 32'(req_cnt), 32'd4);
        check("wait_advance", 32'(state), 32'd7);
        // halt and restart
        cycle(5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 16'h0080);
        cycle(5'd6);
        cycle(5'(($urandom)), 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(5'($urandom), 1'b1);
            check("halt_hold", {16'h0, 11'(state), 4'b0, halted}, {16'h0, 11'd6, 4'b0, 1'b1});
        end
        cycle(5'd10, 1'b0, 1'b1);
        check("halt_restart", {16'h0, 11'(state), 4'b0, halted}, {16'h0, 11'd10, 4'b0, 1'b0});
        // write-through, hold-protection and mem+halt word
        cycle(5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 16'hFFFF);
        check("wthru_fields", {16'h0, 11'(nssel), dbin, ctrl}, {16'h0, 11'd3, 5'd31, 7'h7F});
        cycle(5'd1);
        cycle(5'd1, 1'b0, 1'b1, 1'b1, 5'd9, 16'h0000);
        check("hold_no_write", 32'(ctrl), 32'h7F);
        cycle(5'd1, 1'b1);
        check("memhalt_halted", {16'h0, 11'(state), 3'b0, mem_req, halted}, {16'h0, 11'd9, 3'b0, 1'b0, 1'b1});
        cycle(5'd1, 1'b0, 1'b1);
        check("memhalt_resume", 32'(state), 32'd1);
        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            ns = 5'($urandom);
            wd = 16'($urandom);
            wd[8] = ($urandom_range(0, 3) == 0);
            wd[7] = ($urandom_range(0, 3) == 0);
            wa = ($urandom_range(0, 3) == 0) ? ns : 5'($urandom);
            cycle(ns, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4, wa, wd);
        end
        // asynchronous reset while waiting on memory
        do_reset();
        cycle(5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 16'h0100);
        cycle(5'd4);
        cycle(5'd0);
        check("pre_reset_wait", 32'(mem_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_zero("async_reset_wait");
        nextst = '0; mem_rdy = 1'b0; run = 1'b0; cs_we = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            cycle(5'(i));
            check("cs_cleared", {16'h0, 11'(nssel), dbin, ctrl}, 32'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
